// File: rtl/credit_pkg.sv
// Shared types and constants for the credit/retry link initiator.
// The ID width sets the parking table depth (one entry per ID).
package credit_pkg;

    localparam int ID_W  = 3;
    localparam int PL_W  = 5;
    localparam int N_ENT = 1 << ID_W;

    // Occupancy of the single outgoing link slot
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SEND   = 2'd1,
        REPLAY = 2'd2
    } slot_state_t;

    // One parked transaction, indexed by its ID
    typedef struct packed {
        logic            parked;
        logic            credited;
        logic [PL_W-1:0] payload;
    } park_entry_t;

endpackage

// File: rtl/credit_park_table.sv
// Parking table: one entry per transaction ID holding retried transactions.
// Write order within a cycle is grant, then replay-clear, then park, so a park
// always lands intact. A grant looks at the pre-park contents, so a grant for
// an ID being parked in the same cycle is treated as a stray grant.
module credit_park_table
    import credit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            park_en,
    input  logic [ID_W-1:0] park_id,
    input  logic [PL_W-1:0] park_payload,
    input  logic            gnt_en,
    input  logic [ID_W-1:0] gnt_id,
    input  logic            clr_en,
    input  logic [ID_W-1:0] clr_id,
    input  logic [ID_W-1:0] lookup_id,
    output logic            lookup_parked,
    output logic            pick_valid,
    output logic [ID_W-1:0] pick_id,
    output logic [PL_W-1:0] pick_payload,
    output logic [ID_W:0]   parked_cnt,
    output logic            gnt_err
);

    park_entry_t entries_q [N_ENT];

    // Entry updates, parked-entry count and stray-grant pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ENT; i++) begin
                entries_q[i] <= '0;
            end
            parked_cnt <= '0;
            gnt_err    <= 1'b0;
        end else begin
            gnt_err <= gnt_en & ~entries_q[gnt_id].parked;
            if (gnt_en && entries_q[gnt_id].parked) begin
                entries_q[gnt_id].credited <= 1'b1;
            end
            if (clr_en) begin
                entries_q[clr_id] <= '0;
            end
            if (park_en) begin
                entries_q[park_id] <= '{parked: 1'b1, credited: 1'b0, payload: park_payload};
            end
            // Only parked entries are cleared and only free entries are parked
            case ({park_en, clr_en})
                2'b10:   parked_cnt <= parked_cnt + 1'b1;
                2'b01:   parked_cnt <= parked_cnt - 1'b1;
                default: parked_cnt <= parked_cnt;
            endcase
        end
    end

    // Lowest-index entry that is both parked and credited
    always_comb begin
        pick_valid   = 1'b0;
        pick_id      = '0;
        pick_payload = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (entries_q[i].parked && entries_q[i].credited) begin
                pick_valid   = 1'b1;
                pick_id      = ID_W'(i);
                pick_payload = entries_q[i].payload;
            end
        end
    end

    assign lookup_parked = entries_q[lookup_id].parked;

endmodule

// File: rtl/credit_requester.sv
// Initiator end of the credit/retry link. A single registered slot drives the
// link; retried transactions are parked by ID and replayed with the credit
// flag once the receiver grants a credit. Credited replays always win the
// slot over new local requests so a retried ID makes forward progress.
// Optional deadlock watchdog: define CREDIT_REQ_WDOG_EN.
//
// Handshake: a local transaction transfers when req_valid_i & req_ready_o.
// On the link, while tx_valid_o is high the receiver either accepts
// (tx_ready_i & ~tx_retry_i), retries (tx_retry_i, tx_ready_i ignored) or
// stalls; on a stall id, payload and credit stay stable.
module credit_requester
    import credit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid_i,
    input  logic [ID_W-1:0] req_id_i,
    input  logic [PL_W-1:0] req_payload_i,
    output logic            req_ready_o,
    output logic            tx_valid_o,
    output logic [ID_W-1:0] tx_id_o,
    output logic [PL_W-1:0] tx_payload_o,
    output logic            tx_credit_o,
    input  logic            tx_ready_i,
    input  logic            tx_retry_i,
    input  logic            credit_gnt_i,
    input  logic [ID_W-1:0] credit_id_i,
    output logic [ID_W:0]   parked_cnt_o,
    output logic            err_o,
    output logic            deadlock_o,
    output slot_state_t     slot_state_o
);

    slot_state_t     state_q;
    logic            accept;
    logic            retry;
    logic            slot_free;
    logic            id_busy;
    logic            req_parked;
    logic            pick_valid;
    logic [ID_W-1:0] pick_id;
    logic [PL_W-1:0] pick_payload;
    logic            load_replay;
    logic            load_new;

    assign accept      = tx_valid_o & tx_ready_i & ~tx_retry_i;
    assign retry       = tx_valid_o & tx_retry_i;
    assign slot_free   = ~tx_valid_o | accept | retry;
    // The in-flight ID stays reserved until it is accepted
    assign id_busy     = tx_valid_o & (tx_id_o == req_id_i) & ~accept;
    assign req_ready_o = slot_free & ~pick_valid & ~req_parked & ~id_busy;
    assign load_replay = slot_free & pick_valid;
    assign load_new    = req_valid_i & req_ready_o;

    credit_park_table u_table (
        .clk           (clk),
        .reset         (reset),
        .park_en       (retry),
        .park_id       (tx_id_o),
        .park_payload  (tx_payload_o),
        .gnt_en        (credit_gnt_i),
        .gnt_id        (credit_id_i),
        .clr_en        (load_replay),
        .clr_id        (pick_id),
        .lookup_id     (req_id_i),
        .lookup_parked (req_parked),
        .pick_valid    (pick_valid),
        .pick_id       (pick_id),
        .pick_payload  (pick_payload),
        .parked_cnt    (parked_cnt_o),
        .gnt_err       (err_o)
    );

    // Slot FSM: reload a freed slot with a credited replay, else a new request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            tx_valid_o   <= 1'b0;
            tx_id_o      <= '0;
            tx_payload_o <= '0;
            tx_credit_o  <= 1'b0;
        end else if (slot_free) begin
            if (load_replay) begin
                state_q      <= REPLAY;
                tx_valid_o   <= 1'b1;
                tx_id_o      <= pick_id;
                tx_payload_o <= pick_payload;
                tx_credit_o  <= 1'b1;
            end else if (load_new) begin
                state_q      <= SEND;
                tx_valid_o   <= 1'b1;
                tx_id_o      <= req_id_i;
                tx_payload_o <= req_payload_i;
                tx_credit_o  <= 1'b0;
            end else begin
                state_q      <= EMPTY;
                tx_valid_o   <= 1'b0;
                tx_credit_o  <= 1'b0;
            end
        end
    end

    assign slot_state_o = state_q;

`ifdef CREDIT_REQ_WDOG_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);

    logic [WDOG_W-1:0] wdog_cnt;

    // Count grant-free cycles while anything is parked; flag is sticky
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt   <= '0;
            deadlock_o <= 1'b0;
        end else if (credit_gnt_i || (parked_cnt_o == '0)) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != WDOG_W'(TIMEOUT_CYC)) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt == WDOG_W'(TIMEOUT_CYC - 1)) begin
                deadlock_o <= 1'b1;
            end
        end
    end
`else
    logic unused_wdog_cfg;

    assign unused_wdog_cfg = (TIMEOUT_CYC != 0);
    assign deadlock_o      = 1'b0;
`endif

endmodule

// File: tb/tb_credit_requester.sv
// Bench for credit_requester: cycle table plus directed corner sequences,
// with an accept-order scoreboard on the link side.
module tb_credit_requester;
    import credit_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid_i = 1'b0;
    logic [ID_W-1:0] req_id_i = '0;
    logic [PL_W-1:0] req_payload_i = '0;
    logic            req_ready_o;
    logic            tx_valid_o;
    logic [ID_W-1:0] tx_id_o;
    logic [PL_W-1:0] tx_payload_o;
    logic            tx_credit_o;
    logic            tx_ready_i = 1'b0;
    logic            tx_retry_i = 1'b0;
    logic            credit_gnt_i = 1'b0;
    logic [ID_W-1:0] credit_id_i = '0;
    logic [ID_W:0]   parked_cnt_o;
    logic            err_o;
    logic            deadlock_o;
    slot_state_t     slot_state_o;

    localparam int SB_W = ID_W + PL_W + 1;

    logic [SB_W-1:0] exp_q[$];
    logic [PL_W-1:0] model_pl [N_ENT];
    int checks = 0;
    int errors = 0;
    logic dl_exp;

    credit_requester #(.TIMEOUT_CYC(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid_i),
        .req_id_i      (req_id_i),
        .req_payload_i (req_payload_i),
        .req_ready_o   (req_ready_o),
        .tx_valid_o    (tx_valid_o),
        .tx_id_o       (tx_id_o),
        .tx_payload_o  (tx_payload_o),
        .tx_credit_o   (tx_credit_o),
        .tx_ready_i    (tx_ready_i),
        .tx_retry_i    (tx_retry_i),
        .credit_gnt_i  (credit_gnt_i),
        .credit_id_i   (credit_id_i),
        .parked_cnt_o  (parked_cnt_o),
        .err_o         (err_o),
        .deadlock_o    (deadlock_o),
        .slot_state_o  (slot_state_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rv, input logic [ID_W-1:0] rid, input logic [PL_W-1:0] rpl,
                          input logic rdy, input logic rty, input logic gnt, input logic [ID_W-1:0] gid);
        req_valid_i   = rv;
        req_id_i      = rid;
        req_payload_i = rpl;
        tx_ready_i    = rdy;
        tx_retry_i    = rty;
        credit_gnt_i  = gnt;
        credit_id_i   = gid;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [ID_W-1:0] id, input logic [PL_W-1:0] pl, input logic cr);
        exp_q.push_back({id, pl, cr});
    endtask

    task automatic check_tx(input string name, input logic v, input logic [ID_W-1:0] id,
                            input logic cr, input logic [ID_W:0] cnt);
        check({name, "_valid"}, 32'(tx_valid_o), 32'(v));
        if (v) begin
            check({name, "_id"}, 32'(tx_id_o), 32'(id));
            check({name, "_credit"}, 32'(tx_credit_o), 32'(cr));
        end
        check({name, "_cnt"}, 32'(parked_cnt_o), 32'(cnt));
    endtask

    // Scoreboard: every link accept must match the next expected transaction
    always @(negedge clk) begin
        if (!reset && tx_valid_o && tx_ready_i && !tx_retry_i) begin
            logic [SB_W-1:0] exp_item;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got id=%0d pl=0x%0h cr=%0d required nothing",
                         tx_id_o, tx_payload_o, tx_credit_o);
            end else begin
                exp_item = exp_q.pop_front();
                if ({tx_id_o, tx_payload_o, tx_credit_o} !== exp_item) begin
                    errors++;
                    $display("FAIL sb_accept: got {id,pl,cr}=0x%0h required 0x%0h",
                             {tx_id_o, tx_payload_o, tx_credit_o}, exp_item);
                end
            end
        end
    end

    typedef struct {
        logic            rv;
        logic [ID_W-1:0] rid;
        logic [PL_W-1:0] rpl;
        logic            rdy;
        logic            rty;
        logic            gnt;
        logic [ID_W-1:0] gid;
        logic [1:0]      push;    // 1: new request will be accepted, 2: replay of gid
        logic            e_ready;
        logic            e_valid;
        logic [ID_W-1:0] e_id;
        logic            e_cr;
        logic [ID_W:0]   e_cnt;
        logic            e_err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        for (int i = 0; i < N_ENT; i++) model_pl[i] = '0;

        //            rv rid rpl    rdy rty gnt gid push rdy val id cr cnt err
        vecs[0]  = '{1, 1, 5'h0A, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
        vecs[1]  = '{1, 2, 5'h0B, 1, 0, 0, 0, 1, 1, 1, 2, 0, 0, 0};
        vecs[2]  = '{1, 3, 5'h0C, 1, 0, 0, 0, 1, 1, 1, 3, 0, 0, 0};
        vecs[3]  = '{1, 4, 5'h15, 1, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0};
        vecs[4]  = '{0, 0, 5'h00, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        vecs[5]  = '{0, 0, 5'h00, 0, 0, 1, 4, 2, 1, 0, 0, 0, 1, 0};
        vecs[6]  = '{0, 0, 5'h00, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0};
        vecs[7]  = '{0, 0, 5'h00, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0};
        vecs[8]  = '{0, 0, 5'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 5'h00, 0, 0, 1, 6, 0, 1, 0, 0, 0, 0, 1};
        vecs[10] = '{0, 0, 5'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 5, 5'h11, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0};
        vecs[12] = '{1, 5, 5'h12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        vecs[13] = '{1, 5, 5'h12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

        // Reset
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check("rst_valid", 32'(tx_valid_o), 0);
        check("rst_credit", 32'(tx_credit_o), 0);
        check("rst_cnt", 32'(parked_cnt_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_deadlock", 32'(deadlock_o), 0);
        check("rst_state", 32'(slot_state_o), 32'(EMPTY));
        reset = 1'b0;

        // Cycle table: back-to-back sends, retry/credit/replay, stray grant, ID blocking
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].rv, vecs[i].rid, vecs[i].rpl, vecs[i].rdy, vecs[i].rty,
                   vecs[i].gnt, vecs[i].gid);
            @(negedge clk);
            check($sformatf("v%0d_ready", i), 32'(req_ready_o), 32'(vecs[i].e_ready));
            if (vecs[i].rv && vecs[i].e_ready) model_pl[vecs[i].rid] = vecs[i].rpl;
            if (vecs[i].push == 2'd1) push_exp(vecs[i].rid, vecs[i].rpl, 1'b0);
            if (vecs[i].push == 2'd2) push_exp(vecs[i].gid, model_pl[vecs[i].gid], 1'b1);
            step();
            check_tx($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_id, vecs[i].e_cr, vecs[i].e_cnt);
            check($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].e_err));
        end

        // Reset with ID 5 parked and ID 0 stalled in the slot drops everything
        set_in(1, 0, 5'h01, 0, 0, 0, 0);
        step();
        check_tx("pre_rst", 1, 0, 0, 1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check_tx("mid_rst", 0, 0, 0, 0);
        step();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 1, 5);
        step();
        check("rst_drop_err", 32'(err_o), 1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        check("rst_drop_err_clr", 32'(err_o), 0);
        check_tx("rst_no_replay", 0, 0, 0, 0);

        // Parked ID 2 blocks a new request with ID 2 until its replay is accepted
        set_in(1, 2, 5'h07, 0, 0, 0, 0);
        @(negedge clk);
        check("a_first_ready", 32'(req_ready_o), 1);
        step();
        check_tx("a_sent", 1, 2, 0, 0);
        set_in(0, 0, 0, 0, 1, 0, 0);
        step();
        check_tx("a_parked", 0, 0, 0, 1);
        set_in(1, 2, 5'h08, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("a_blocked", 32'(req_ready_o), 0);
            step();
        end
        check_tx("a_wait", 0, 0, 0, 1);
        set_in(1, 2, 5'h08, 0, 0, 1, 2);
        @(negedge clk);
        check("a_gnt_ready", 32'(req_ready_o), 0);
        push_exp(2, 5'h07, 1'b1);
        step();
        set_in(1, 2, 5'h08, 0, 0, 0, 0);
        @(negedge clk);
        check("a_pick_ready", 32'(req_ready_o), 0);
        step();
        check_tx("a_replay", 1, 2, 1, 0);
        check("a_replay_pl", 32'(tx_payload_o), 32'h07);
        @(negedge clk);
        check("a_stall_ready", 32'(req_ready_o), 0);
        step();
        check_tx("a_stall", 1, 2, 1, 0);
        tx_ready_i = 1'b1;
        @(negedge clk);
        check("a_release_ready", 32'(req_ready_o), 1);
        push_exp(2, 5'h08, 1'b0);
        step();
        check_tx("a_new", 1, 2, 0, 0);
        set_in(0, 0, 0, 1, 0, 0, 0);
        step();
        check_tx("a_done", 0, 0, 0, 0);

        // Credits for 5 then 3 while the slot is busy: 3 replays, then 5, then the new request
        set_in(1, 5, 5'h05, 0, 0, 0, 0);
        step();
        check_tx("b_send5", 1, 5, 0, 0);
        set_in(1, 3, 5'h03, 0, 1, 0, 0);
        @(negedge clk);
        check("b_ready3", 32'(req_ready_o), 1);
        step();
        check_tx("b_send3", 1, 3, 0, 1);
        set_in(1, 6, 5'h06, 0, 1, 0, 0);
        @(negedge clk);
        check("b_ready6", 32'(req_ready_o), 1);
        push_exp(6, 5'h06, 1'b0);
        step();
        check_tx("b_send6", 1, 6, 0, 2);
        set_in(0, 0, 0, 0, 0, 1, 5);
        step();
        check_tx("b_gnt5", 1, 6, 0, 2);
        set_in(0, 0, 0, 0, 0, 1, 3);
        push_exp(3, 5'h03, 1'b1);
        push_exp(5, 5'h05, 1'b1);
        step();
        check_tx("b_gnt3", 1, 6, 0, 2);
        check("b_gnt_err", 32'(err_o), 0);
        set_in(1, 7, 5'h1F, 1, 0, 0, 0);
        @(negedge clk);
        check("b_hold7_a", 32'(req_ready_o), 0);
        step();
        check_tx("b_rep3", 1, 3, 1, 1);
        @(negedge clk);
        check("b_hold7_b", 32'(req_ready_o), 0);
        step();
        check_tx("b_rep5", 1, 5, 1, 0);
        @(negedge clk);
        check("b_ready7", 32'(req_ready_o), 1);
        push_exp(7, 5'h1F, 1'b0);
        step();
        check_tx("b_new7", 1, 7, 0, 0);
        set_in(0, 0, 0, 1, 0, 0, 0);
        step();
        check_tx("b_done", 0, 0, 0, 0);

        // Park ID 1 and never grant: watchdog fires after TIMEOUT_CYC cycles
`ifdef CREDIT_REQ_WDOG_EN
        dl_exp = 1'b1;
`else
        dl_exp = 1'b0;
`endif
        set_in(1, 1, 5'h09, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 1, 0, 0);
        step();
        check_tx("w_parked", 0, 0, 0, 1);
        tx_retry_i = 1'b0;
        for (int k = 0; k < 7; k++) step();
        check("w_before", 32'(deadlock_o), 0);
        step();
        check("w_fire", 32'(deadlock_o), 32'(dl_exp));
        for (int k = 0; k < 5; k++) step();
        check("w_sticky", 32'(deadlock_o), 32'(dl_exp));
        reset = 1'b1;
        #1;
        check("w_rst", 32'(deadlock_o), 0);
        check("w_rst_cnt", 32'(parked_cnt_o), 0);
        step();
        reset = 1'b0;
        step();

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
